// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
// Sequences the program counter and runs the instruction-memory fetch
// handshake. The external PC register has no enable, so this block computes
// its next value every cycle. Holding the PC means feeding pc_value back.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   pc_value        current PC read back from the PC register
//   next_pc         value loaded into the PC register every clock (comb.)
//   imem_req        fetch request at address pc_value
//   imem_ready      memory accepts/completes the request this cycle
//   stall           decode stage cannot take an instruction
//   redirect_valid  single-cycle branch/jump redirect strobe
//   redirect_target redirect destination
//   halt / resume   enter / leave the HALTED state
//   fetch_valid     instruction at fetch_pc delivered to decode this cycle
//   fetch_pc        address of the delivered instruction
//   misalign_err    sticky misaligned-target flag, cleared only by reset
//   fetch_count     wrapping count of delivered instructions
module pc_fetch_controller #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = 32'h0040_0000,
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc_value,
  output logic [N-1:0]     next_pc,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [N-1:0]     redirect_target,
  input  logic             halt,
  input  logic             resume,
  output logic             fetch_valid,
  output logic [N-1:0]     fetch_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_HOLD   = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [N-1:0]     PC_STEP  = {{(N-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     ADDR_ZERO = {N{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [N-1:0] addr);
    is_misaligned = (addr[1:0] != 2'b00);
  endfunction

  logic [2:0]       state_r;
  logic             pend_valid_r;
  logic [N-1:0]     pend_addr_r;
  logic [CNT_W-1:0] fetch_count_r;
  logic             misalign_err_r;

  logic [2:0]       state_nxt_s;
  logic             pend_valid_nxt_s;
  logic [N-1:0]     pend_addr_nxt_s;
  logic             count_inc_s;
  logic             set_err_s;
  logic [N-1:0]     next_pc_s;
  logic             imem_req_s;
  logic             fetch_valid_s;

  // A live strobe beats an older pending redirect.
  logic             eff_valid_s;
  logic [N-1:0]     eff_target_s;
  logic             eff_misalign_s;

  assign eff_valid_s    = redirect_valid | pend_valid_r;
  assign eff_target_s   = redirect_valid ? redirect_target : pend_addr_r;
  assign eff_misalign_s = is_misaligned(eff_target_s);

  // Next-state, next-PC and handshake decode.
  always_comb begin
    state_nxt_s      = state_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_addr_nxt_s  = pend_addr_r;
    next_pc_s        = pc_value;
    imem_req_s       = 1'b0;
    fetch_valid_s    = 1'b0;
    count_inc_s      = 1'b0;
    set_err_s        = 1'b0;
    case (state_r)
      ST_BOOT: begin
        next_pc_s   = RESET_PC;
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (eff_valid_s) begin
          next_pc_s        = eff_target_s;
          pend_valid_nxt_s = 1'b0;
        end else begin
          next_pc_s = pc_value;
        end
        if (eff_valid_s && eff_misalign_s) begin
          state_nxt_s = ST_ERR;
          set_err_s   = 1'b1;
        end else if (halt) begin
          state_nxt_s = ST_HALTED;
        end else if (!stall) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_REQ: begin
        // The request is held until the memory completes it, whatever
        // stall/halt/redirect do in the meantime.
        imem_req_s = 1'b1;
        if (!imem_ready) begin
          next_pc_s = pc_value;
          if (redirect_valid) begin
            pend_valid_nxt_s = 1'b1;
            pend_addr_nxt_s  = redirect_target;
          end else begin
            pend_valid_nxt_s = pend_valid_r;
          end
        end else if (eff_valid_s) begin
          // The instruction just returned is on the wrong path: squash it.
          next_pc_s        = eff_target_s;
          pend_valid_nxt_s = 1'b0;
          if (eff_misalign_s) begin
            state_nxt_s = ST_ERR;
            set_err_s   = 1'b1;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end else begin
          fetch_valid_s = 1'b1;
          next_pc_s     = pc_value + PC_STEP;
          count_inc_s   = 1'b1;
          if (halt) begin
            state_nxt_s = ST_HALTED;
          end else if (!stall) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
      end
      ST_HALTED: begin
        // Redirects are only captured here; HOLD applies them after resume.
        next_pc_s = pc_value;
        if (redirect_valid) begin
          pend_valid_nxt_s = 1'b1;
          pend_addr_nxt_s  = redirect_target;
        end else begin
          pend_valid_nxt_s = pend_valid_r;
        end
        if (resume && !halt) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      ST_ERR: begin
        next_pc_s   = pc_value;
        state_nxt_s = ST_ERR;
      end
      default: begin
        // Unreachable encodings restart the boot sequence.
        next_pc_s   = RESET_PC;
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // State, pending redirect, counter and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_BOOT;
      pend_valid_r   <= 1'b0;
      pend_addr_r    <= ADDR_ZERO;
      fetch_count_r  <= CNT_ZERO;
      misalign_err_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      pend_valid_r   <= pend_valid_nxt_s;
      pend_addr_r    <= pend_addr_nxt_s;
      if (count_inc_s) begin
        fetch_count_r <= fetch_count_r + CNT_ONE;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      misalign_err_r <= misalign_err_r | set_err_s;
    end
  end

  assign next_pc      = next_pc_s;
  assign imem_req     = imem_req_s;
  assign fetch_valid  = fetch_valid_s;
  assign fetch_pc     = pc_value;
  assign misalign_err = misalign_err_r;
  assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Testbench for pc_fetch_controller: directed stimulus pushes the expected
// delivered addresses into a queue; a monitor pops and compares on every
// fetch_valid. The PC register is modelled here as a plain flop on next_pc.
module tb_pc_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_value;
  logic [31:0] next_pc;
  logic        imem_req;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        resume;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  logic [3:0]  fetch_count;

  int          checks = 0;
  int          errors = 0;
  int          seen   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // External PC register (no enable, no reset).
  always @(posedge clk) pc_value <= next_pc;

  pc_fetch_controller #(
    .N        (32),
    .RESET_PC (32'h0040_0000),
    .CNT_W    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_value        (pc_value),
    .next_pc         (next_pc),
    .imem_req        (imem_req),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .resume          (resume),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: every delivered instruction must match the next queued address,
  // and fetch_count must equal the number of deliveries before it (mod 16).
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 0;
      end else if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got fetch_pc 0x%08h, expected no delivery", fetch_pc);
        end else begin
          chk("fetch_pc", fetch_pc, exp_q.pop_front());
        end
        chk("fetch_count", {28'd0, fetch_count}, 32'(seen % 16));
        seen++;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; halt = 1'b0; resume = 1'b0;
    repeat (2) neg();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_next_pc", next_pc, RST_PC);
    chk("rst_count", {28'd0, fetch_count}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);

    // Boot with continuous fetch.
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0008);
    tick(); reset = 1'b1;                       // BOOT
    neg(); chk("boot_next_pc", next_pc, RST_PC);
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    tick();                                     // HOLD
    neg(); chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_next_pc", next_pc, RST_PC);
    tick();                                     // fetch 0x400000
    tick();                                     // fetch 0x400004
    tick(); stall = 1'b1;                       // fetch 0x400008 -> HOLD
    tick();                                     // HOLD, pc 0x40000C

    // Three wait states, then completion.
    imem_ready = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      neg(); chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_next_pc", next_pc, 32'h0040_000C);
    end
    exp_q.push_back(32'h0040_000C);
    tick(); imem_ready = 1'b1; stall = 1'b1;
    neg(); chk("done_req", {31'd0, imem_req}, 32'd1);
    chk("done_next_pc", next_pc, 32'h0040_0010);
    tick();                                     // HOLD, pc 0x400010

    // Redirect during a wait state squashes the returning instruction.
    stall = 1'b0; imem_ready = 1'b0;
    tick();                                     // REQ waiting
    redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    tick(); redirect_valid = 1'b0;
    tick(); imem_ready = 1'b1;                  // completion with pending
    neg(); chk("squash_valid", {31'd0, fetch_valid}, 32'd0);
    chk("squash_next_pc", next_pc, 32'h0040_0100);
    exp_q.push_back(32'h0040_0100);
    tick();                                     // HOLD
    tick();                                     // fetch 0x400100
    tick(); imem_ready = 1'b0;                  // REQ 0x400104 waiting
    redirect_valid = 1'b1; redirect_target = 32'h0040_0180;
    tick(); redirect_target = 32'h0040_0200;    // later redirect wins
    tick(); redirect_valid = 1'b0; imem_ready = 1'b1;
    neg(); chk("second_redirect_pc", next_pc, 32'h0040_0200);
    chk("second_squash", {31'd0, fetch_valid}, 32'd0);
    exp_q.push_back(32'h0040_0200);
    tick();                                     // HOLD
    tick(); halt = 1'b1;                        // fetch 0x400200 -> HALTED

    // Halt, redirect while halted, resume.
    tick(); halt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0040;
    neg(); chk("halted_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("halted_idle_req", {31'd0, imem_req}, 32'd0);
      chk("halted_next_pc", next_pc, 32'h0040_0204);
      tick();
    end
    halt = 1'b1; resume = 1'b1;
    tick(); halt = 1'b0;
    neg(); chk("halt_and_resume_stays", next_pc, 32'h0040_0204);
    tick(); resume = 1'b0;                      // HOLD applies pending
    neg(); chk("resume_next_pc", next_pc, 32'h0040_0040);
    chk("resume_hold_req", {31'd0, imem_req}, 32'd0);
    exp_q.push_back(32'h0040_0040);
    tick();                                     // fetch 0x400040
    tick(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0;              // HOLD at 0xFFFFFFF8

    // Address wrap and counter wrap (16 deliveries total).
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0008);
    exp_q.push_back(32'h0000_000C);
    exp_q.push_back(32'h0000_0010);
    exp_q.push_back(32'h0000_0014);
    exp_q.push_back(32'h0000_0018);
    tick();                                     // fetch 0xFFFFFFF8
    tick();                                     // fetch 0xFFFFFFFC
    neg(); chk("wrap_next_pc", next_pc, 32'h0000_0000);
    repeat (6) tick();
    tick(); stall = 1'b1;                       // 16th delivery -> HOLD
    tick(); redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
    neg(); chk("count_wrap", {28'd0, fetch_count}, 32'd0);
    chk("misalign_next_pc", next_pc, 32'h0040_0102);

    // ERR is terminal until reset.
    tick(); redirect_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("err_flag", {31'd0, misalign_err}, 32'd1);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_next_pc", next_pc, 32'h0040_0102);
      tick();
    end
    reset = 1'b0;
    neg(); chk("rst_clears_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_err_req", {31'd0, imem_req}, 32'd0);

    // Restart from the boot address, then reset mid-transaction.
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    tick(); reset = 1'b1;                       // BOOT
    tick();                                     // HOLD
    tick();                                     // fetch 0x400000
    tick(); stall = 1'b1;                       // fetch 0x400004 -> HOLD
    tick(); stall = 1'b0; imem_ready = 1'b0;
    tick();                                     // REQ waiting
    neg(); chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_count", {28'd0, fetch_count}, 32'd2);
    tick(); reset = 1'b0;
    neg(); chk("mid_rst_req_drop", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_count", {28'd0, fetch_count}, 32'd0);
    tick(); reset = 1'b1; imem_ready = 1'b1; stall = 1'b1;
    repeat (3) tick();
    neg(); chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
